// File: rtl/decoder_scan_nx2n.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable and dwell-timed auto-scan.
// Define DECODER_SCAN_BOUNCE_EN to make the scan run ping-pong instead of modulo-N upward.
module decoder_scan_nx2n #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   o,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] IDX_MIN = '0;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN_LOAD,
    SCAN
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [N-1:0]         o_q, o_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
`ifdef DECODER_SCAN_BOUNCE_EN
  logic                 up_q, up_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
`ifdef DECODER_SCAN_BOUNCE_EN
    up_d    = up_q;
`endif

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        // Entering either DIRECT or SCAN_LOAD decodes sel on this same edge.
        IDLE, DIRECT: begin
          idx_d   = sel;
          state_d = mode ? SCAN_LOAD : DIRECT;
        end
        SCAN_LOAD: begin
          idx_d   = sel;
          cnt_d   = dwell;
          state_d = SCAN;
`ifdef DECODER_SCAN_BOUNCE_EN
          up_d    = 1'b1;
`endif
        end
        SCAN: begin
          if (!mode) begin
            // A mode change outranks a simultaneous dwell expiry.
            idx_d   = sel;
            state_d = DIRECT;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = dwell;
`ifdef DECODER_SCAN_BOUNCE_EN
            if (up_q) begin
              if (idx_q == IDX_MAX) begin
                idx_d  = idx_q - 1'b1;
                up_d   = 1'b0;
                wrap_d = 1'b1;
              end else begin
                idx_d  = idx_q + 1'b1;
              end
            end else begin
              if (idx_q == IDX_MIN) begin
                idx_d  = idx_q + 1'b1;
                up_d   = 1'b1;
                wrap_d = 1'b1;
              end else begin
                idx_d  = idx_q - 1'b1;
              end
            end
`else
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == IDX_MAX);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // o is derived from the next index, so it can only ever be zero or one-hot.
    o_d = '0;
    if (en) begin
      o_d[idx_d] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef DECODER_SCAN_BOUNCE_EN
      up_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
`ifdef DECODER_SCAN_BOUNCE_EN
      up_q    <= up_d;
`endif
    end
  end

  assign o    = o_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Directed bench for decoder_scan_nx2n (SEL_W=2): expected outputs are queued as each
// step is driven and popped/compared one clock later.
module tb_decoder_scan_nx2n;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;
  localparam int N       = 1 << SEL_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       o;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  typedef struct {
    string            tag;
    logic [N-1:0]     o;
    logic [SEL_W-1:0] idx;
    logic             wrap;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  decoder_scan_nx2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .dwell (dwell),
    .o     (o),
    .idx   (idx),
    .wrap  (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Queue an expectation: 'on' selects a one-hot o at index xi, otherwise all-zero.
  task automatic expect_out(input string tag, input logic on, input logic [SEL_W-1:0] xi,
                            input logic xw);
    exp_t x;
    x.tag  = tag;
    x.idx  = xi;
    x.wrap = xw;
    x.o    = '0;
    if (on) x.o[xi] = 1'b1;
    sb.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    x = sb.pop_front();
    check({x.tag, "_o"},      32'(o),          32'(x.o));
    check({x.tag, "_idx"},    32'(idx),        32'(x.idx));
    check({x.tag, "_wrap"},   32'(wrap),       32'(x.wrap));
    check({x.tag, "_onehot"}, 32'($onehot0(o)), 32'd1);
  endtask

  task automatic step(input logic e, input logic m, input logic [SEL_W-1:0] s,
                      input logic [DWELL_W-1:0] d, input logic on,
                      input logic [SEL_W-1:0] xi, input logic xw, input string tag);
    en    = e;
    mode  = m;
    sel   = s;
    dwell = d;
    expect_out(tag, on, xi, xw);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = '0;
    dwell = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 2'd0, 1'b0);
    compare_out();
    #2 rst_n = 1'b1;

    // Direct decode, one cycle of latency.
    step(1, 0, 2'd0, 4'd0, 1, 2'd0, 0, "dir0");
    step(1, 0, 2'd1, 4'd0, 1, 2'd1, 0, "dir1");
    step(1, 0, 2'd2, 4'd0, 1, 2'd2, 0, "dir2");
    step(1, 0, 2'd3, 4'd0, 1, 2'd3, 0, "dir3");

    // Enable gating: idx holds while disabled, even if sel moves.
    step(1, 0, 2'd2, 4'd0, 1, 2'd2, 0, "en_pre");
    step(0, 0, 2'd2, 4'd0, 0, 2'd2, 0, "en_off");
    step(0, 0, 2'd0, 4'd0, 0, 2'd2, 0, "en_off_hold");
    step(1, 0, 2'd2, 4'd0, 1, 2'd2, 0, "en_on");

`ifdef DECODER_SCAN_BOUNCE_EN
    // Ping-pong scan, dwell = 0, start at 0.
    step(1, 0, 2'd2, 4'd0, 1, 2'd2, 0, "b_dir");
    step(1, 1, 2'd0, 4'd0, 1, 2'd0, 0, "b_enter");
    step(1, 1, 2'd0, 4'd0, 1, 2'd0, 0, "b_load");
    step(1, 1, 2'd0, 4'd0, 1, 2'd1, 0, "b_1");
    step(1, 1, 2'd0, 4'd0, 1, 2'd2, 0, "b_2");
    step(1, 1, 2'd0, 4'd0, 1, 2'd3, 0, "b_3");
    step(1, 1, 2'd0, 4'd0, 1, 2'd2, 1, "b_3to2");
    step(1, 1, 2'd0, 4'd0, 1, 2'd1, 0, "b_1dn");
    step(1, 1, 2'd0, 4'd0, 1, 2'd0, 0, "b_0");
    step(1, 1, 2'd0, 4'd0, 1, 2'd1, 1, "b_0to1");
    step(1, 1, 2'd0, 4'd0, 1, 2'd2, 0, "b_2up");
`else
    // Modulo scan, dwell = 0, start at 1; sel change mid-scan is ignored.
    step(1, 1, 2'd1, 4'd0, 1, 2'd1, 0, "s0_enter");
    step(1, 1, 2'd1, 4'd0, 1, 2'd1, 0, "s0_load");
    step(1, 1, 2'd1, 4'd0, 1, 2'd2, 0, "s0_2");
    step(1, 1, 2'd1, 4'd0, 1, 2'd3, 0, "s0_3");
    step(1, 1, 2'd1, 4'd0, 1, 2'd0, 1, "s0_wrap");
    step(1, 1, 2'd1, 4'd0, 1, 2'd1, 0, "s0_1");
    step(1, 1, 2'd3, 4'd0, 1, 2'd2, 0, "s0_selign");
    step(1, 1, 2'd3, 4'd0, 1, 2'd3, 0, "s0_3b");
    step(1, 1, 2'd3, 4'd0, 1, 2'd0, 1, "s0_wrap2");
    step(1, 0, 2'd3, 4'd0, 1, 2'd3, 0, "s0_todir");

    // Modulo scan, dwell = 2, start at 3; each line held three cycles.
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_enter");
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_load");
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_3c1");
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_3c0");
    step(1, 1, 2'd3, 4'd2, 1, 2'd0, 1, "s2_wrap");
    step(1, 1, 2'd3, 4'd2, 1, 2'd0, 0, "s2_0c1");
    step(1, 1, 2'd3, 4'd2, 1, 2'd0, 0, "s2_0c0");
    step(1, 1, 2'd3, 4'd2, 1, 2'd1, 0, "s2_1c2");
    step(1, 1, 2'd3, 4'd2, 1, 2'd1, 0, "s2_1c1");
    step(1, 1, 2'd3, 4'd2, 1, 2'd1, 0, "s2_1c0");
    step(1, 1, 2'd3, 4'd2, 1, 2'd2, 0, "s2_2c2");
    step(1, 1, 2'd3, 4'd2, 1, 2'd2, 0, "s2_2c1");
    step(1, 1, 2'd3, 4'd2, 1, 2'd2, 0, "s2_2c0");
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_3c2");
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_3c1b");
    step(1, 1, 2'd3, 4'd2, 1, 2'd3, 0, "s2_3c0b");
    // Expiry at N-1 coincides with mode = 0: no advance, no wrap, decode sel.
    step(1, 0, 2'd1, 4'd2, 1, 2'd1, 0, "s2_modewin");
`endif

    // Async reset mid-scan while idx = 2.
    step(1, 1, 2'd0, 4'd0, 1, 2'd0, 0, "r_enter");
    step(1, 1, 2'd0, 4'd0, 1, 2'd0, 0, "r_load");
    step(1, 1, 2'd0, 4'd0, 1, 2'd1, 0, "r_1");
    step(1, 1, 2'd0, 4'd0, 1, 2'd2, 0, "r_2");
    #2 rst_n = 1'b0;
    #1;
    expect_out("r_async", 1'b0, 2'd0, 1'b0);
    compare_out();
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 2'd2, 4'd0, 0, 2'd0, 0, "r_idle0");
    step(0, 1, 2'd2, 4'd0, 0, 2'd0, 0, "r_idle1");
    step(1, 0, 2'd2, 4'd0, 1, 2'd2, 0, "r_resume");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
